alu_exec_stage: RTL and testbench

ALU_EXEC_STAGE -- requirements
Module: alu_exec_stage

---
 rtl/alu_exec_stage_pkg.sv | 55 +++++
 rtl/alu_exec_stage_alu.sv | 146 ++++++++++++++
 rtl/alu_exec_stage.sv | 154 +++++++++++++++
 tb/tb_alu_exec_stage.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_exec_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_exec_stage_pkg
// Description : Shared definitions for the ALU execute stage: datapath widths,
//               MATH_* opcode encodings, flag bit indices and helpers.
// Contents    : DATA_W/OP_W/DEST_W/FLAG_W widths, MATH_* opcodes,
//               FLAG_* indices, op_is_known(), op_writes_reg()
// Revision    : 1.0 - initial release
// ============================================================================
package alu_exec_stage_pkg;

  localparam int DATA_W = 8;
  localparam int OP_W   = 7;
  localparam int DEST_W = 3;
  localparam int FLAG_W = 7;

  // Opcode encodings
  localparam logic [OP_W-1:0] MATH_ADD = 7'h01;
  localparam logic [OP_W-1:0] MATH_SUB = 7'h02;
  localparam logic [OP_W-1:0] MATH_AND = 7'h03;
  localparam logic [OP_W-1:0] MATH_OR  = 7'h04;
  localparam logic [OP_W-1:0] MATH_XOR = 7'h05;
  localparam logic [OP_W-1:0] MATH_CMP = 7'h06;
  localparam logic [OP_W-1:0] MATH_DIV = 7'h07;
  localparam logic [OP_W-1:0] MATH_MOD = 7'h08;
  localparam logic [OP_W-1:0] MATH_MUL = 7'h09;
  localparam logic [OP_W-1:0] MATH_SHL = 7'h0A;
  localparam logic [OP_W-1:0] MATH_SHR = 7'h0B;

  // Flag vector layout: {carry, equal, less_than, zero, one, overflow, undefined}
  localparam int FLAG_CARRY = 6;
  localparam int FLAG_EQUAL = 5;
  localparam int FLAG_LT    = 4;
  localparam int FLAG_ZERO  = 3;
  localparam int FLAG_ONE   = 2;
  localparam int FLAG_OVF   = 1;
  localparam int FLAG_UNDEF = 0;

  function automatic logic op_is_known(input logic [OP_W-1:0] op);
    logic known;
    case (op)
      MATH_ADD, MATH_SUB, MATH_AND, MATH_OR, MATH_XOR, MATH_CMP,
      MATH_DIV, MATH_MOD, MATH_MUL, MATH_SHL, MATH_SHR: known = 1'b1;
      default:                                          known = 1'b0;
    endcase
    return known;
  endfunction

  // CMP only produces flags; unknown opcodes must never corrupt a register.
  function automatic logic op_writes_reg(input logic [OP_W-1:0] op);
    return op_is_known(op) && (op != MATH_CMP);
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_exec_stage_alu.sv
`default_nettype none
// ============================================================================
// Module      : alu_exec_stage_alu
// Description : Purely combinational 8-bit ALU producing a result and a
//               7-bit flag vector.
// Ports       : i_A, i_B    - operands
//               i_signed    - signed mode for overflow / compare / div / shr
//               i_op        - MATH_* opcode
//               o_G         - result
//               o_flags     - {carry, equal, less_than, zero, one, ovf, undef}
// Revision    : 1.0 - initial release
// ============================================================================
module alu_exec_stage_alu
  import alu_exec_stage_pkg::*;
(
  input  logic [DATA_W-1:0] i_A,
  input  logic [DATA_W-1:0] i_B,
  input  logic              i_signed,
  input  logic [OP_W-1:0]   i_op,
  output logic [DATA_W-1:0] o_G,
  output logic [FLAG_W-1:0] o_flags
);

  logic [DATA_W:0]            w_add;
  logic [DATA_W:0]            w_sub;
  logic [2*DATA_W-1:0]        w_mul_u;
  logic signed [2*DATA_W-1:0] w_mul_s;
  logic [DATA_W-1:0]          w_divisor;
  logic [DATA_W-1:0]          w_div_u;
  logic [DATA_W-1:0]          w_mod_u;
  logic signed [DATA_W:0]     w_div_s;
  logic signed [DATA_W-1:0]   w_mod_s;
  logic [2:0]                 w_shamt;
  logic [DATA_W:0]            w_shl;
  logic [DATA_W-1:0]          w_srl;
  logic signed [DATA_W-1:0]   w_sra;
  logic                       w_lt;
  logic                       w_add_sovf;
  logic                       w_sub_sovf;
  logic                       w_mul_sovf;
  logic [DATA_W-1:0]          w_g;
  logic                       w_carry;
  logic                       w_ovf;
  logic                       w_undef;

  assign w_add   = {1'b0, i_A} + {1'b0, i_B};
  assign w_sub   = {1'b0, i_A} - {1'b0, i_B};
  assign w_mul_u = {{DATA_W{1'b0}}, i_A} * {{DATA_W{1'b0}}, i_B};
  assign w_mul_s = $signed({{DATA_W{i_A[DATA_W-1]}}, i_A}) *
                   $signed({{DATA_W{i_B[DATA_W-1]}}, i_B});

  // A zero divisor is replaced so the dividers never see /0; the result for
  // that case is chosen explicitly below and flagged undefined.
  assign w_divisor = (i_B == '0) ? 8'd1 : i_B;
  assign w_div_u   = i_A / w_divisor;
  assign w_mod_u   = i_A % w_divisor;
  // One extra bit so that -128 / -1 = +128 is representable and detectable.
  assign w_div_s   = $signed({i_A[DATA_W-1], i_A}) /
                     $signed({w_divisor[DATA_W-1], w_divisor});
  assign w_mod_s   = $signed(i_A) % $signed(w_divisor);

  assign w_shamt = i_B[2:0];
  assign w_shl   = {1'b0, i_A} << w_shamt;
  assign w_srl   = i_A >> w_shamt;
  // Kept in its own signed net so >>> stays arithmetic.
  assign w_sra   = $signed(i_A) >>> w_shamt;

  assign w_lt = i_signed ? ($signed(i_A) < $signed(i_B)) : (i_A < i_B);

  assign w_add_sovf = (i_A[DATA_W-1] == i_B[DATA_W-1]) &&
                      (w_add[DATA_W-1] != i_A[DATA_W-1]);
  assign w_sub_sovf = (i_A[DATA_W-1] != i_B[DATA_W-1]) &&
                      (w_sub[DATA_W-1] != i_A[DATA_W-1]);
  // Signed product fits in 8 bits only if the upper 9 bits are all equal.
  assign w_mul_sovf = (w_mul_s[2*DATA_W-1:DATA_W-1] != {(DATA_W+1){w_mul_s[DATA_W-1]}});

  always_comb begin
    w_g     = '0;
    w_carry = 1'b0;
    w_ovf   = 1'b0;
    w_undef = 1'b0;
    case (i_op)
      MATH_ADD: begin
        w_g     = w_add[DATA_W-1:0];
        w_carry = w_add[DATA_W];
        // Unsigned mode reports carry-out as overflow.
        w_ovf   = i_signed ? w_add_sovf : w_add[DATA_W];
      end
      MATH_SUB, MATH_CMP: begin
        w_g     = w_sub[DATA_W-1:0];
        w_carry = w_sub[DATA_W];
        w_ovf   = i_signed ? w_sub_sovf : w_sub[DATA_W];
      end
      MATH_AND: w_g = i_A & i_B;
      MATH_OR:  w_g = i_A | i_B;
      MATH_XOR: w_g = i_A ^ i_B;
      MATH_MUL: begin
        w_g     = w_mul_u[DATA_W-1:0];
        w_carry = |w_mul_u[2*DATA_W-1:DATA_W];
        w_ovf   = i_signed ? w_mul_sovf : (|w_mul_u[2*DATA_W-1:DATA_W]);
      end
      MATH_DIV: begin
        if (i_B == '0) begin
          w_g     = '1;
          w_undef = 1'b1;
        end else if (i_signed) begin
          w_g   = w_div_s[DATA_W-1:0];
          w_ovf = (w_div_s[DATA_W] != w_div_s[DATA_W-1]);
        end else begin
          w_g = w_div_u;
        end
      end
      MATH_MOD: begin
        if (i_B == '0) begin
          w_g     = i_A;
          w_undef = 1'b1;
        end else if (i_signed) begin
          w_g = w_mod_s;
        end else begin
          w_g = w_mod_u;
        end
      end
      MATH_SHL: begin
        w_g     = w_shl[DATA_W-1:0];
        w_carry = w_shl[DATA_W];
      end
      MATH_SHR: w_g = i_signed ? w_sra : w_srl;
      default:  w_undef = 1'b1;
    endcase
  end

  always_comb begin
    o_flags             = '0;
    o_flags[FLAG_CARRY] = w_carry;
    o_flags[FLAG_EQUAL] = (i_A == i_B);
    o_flags[FLAG_LT]    = w_lt;
    o_flags[FLAG_ZERO]  = (w_g == '0);
    o_flags[FLAG_ONE]   = (w_g == 8'd1);
    o_flags[FLAG_OVF]   = w_ovf;
    o_flags[FLAG_UNDEF] = w_undef;
  end

  assign o_G = w_g;

endmodule
`default_nettype wire

// File: rtl/alu_exec_stage.sv
`default_nettype none
// ============================================================================
// Module      : alu_exec_stage
// Description : Two-stage valid/ready ALU execute pipeline. S1 registers the
//               operands, the ALU sits between S1 and S2, S2 registers the
//               result. Retired flags are kept in o_status and overflow /
//               undefined are accumulated in sticky bits.
// Ports       : i_clk, i_rst_n            - clock, async active-low reset
//               i_valid/o_ready           - upstream handshake
//               i_A, i_B, i_signed, i_op, i_dest - operation
//               o_valid/i_ready           - downstream handshake
//               o_G, o_dest, o_we, o_flags - registered result
//               o_status                  - flags of last retired result
//               o_sticky_ovf/undef, i_clr_sticky - sticky error bits
//               o_busy                    - any stage occupied
// Revision    : 1.0 - initial release
// ============================================================================
module alu_exec_stage
  import alu_exec_stage_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [DATA_W-1:0] i_A,
  input  logic [DATA_W-1:0] i_B,
  input  logic              i_signed,
  input  logic [OP_W-1:0]   i_op,
  input  logic [DEST_W-1:0] i_dest,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_G,
  output logic [DEST_W-1:0] o_dest,
  output logic              o_we,
  output logic [FLAG_W-1:0] o_flags,
  output logic [FLAG_W-1:0] o_status,
  output logic              o_sticky_ovf,
  output logic              o_sticky_undef,
  input  logic              i_clr_sticky,
  output logic              o_busy
);

  // S1: operand register
  logic              r_s1_valid;
  logic [DATA_W-1:0] r_s1_a;
  logic [DATA_W-1:0] r_s1_b;
  logic              r_s1_signed;
  logic [OP_W-1:0]   r_s1_op;
  logic [DEST_W-1:0] r_s1_dest;

  // S2: result register
  logic              r_s2_valid;
  logic [DATA_W-1:0] r_s2_g;
  logic [DEST_W-1:0] r_s2_dest;
  logic              r_s2_we;
  logic [FLAG_W-1:0] r_s2_flags;

  logic [FLAG_W-1:0] r_status;
  logic              r_sticky_ovf;
  logic              r_sticky_undef;

  logic [DATA_W-1:0] w_alu_g;
  logic [FLAG_W-1:0] w_alu_flags;
  logic              w_accept;
  logic              w_s2_load;
  logic              w_retire;

  alu_exec_stage_alu u_alu (
    .i_A      (r_s1_a),
    .i_B      (r_s1_b),
    .i_signed (r_s1_signed),
    .i_op     (r_s1_op),
    .o_G      (w_alu_g),
    .o_flags  (w_alu_flags)
  );

  // Ready looks through to i_ready so a full pipe can still take one
  // operation per cycle while draining.
  assign o_ready   = !r_s1_valid || !r_s2_valid || i_ready;
  assign w_accept  = i_valid && o_ready;
  assign w_retire  = r_s2_valid && i_ready;
  assign w_s2_load = r_s1_valid && (!r_s2_valid || i_ready);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1_valid  <= 1'b0;
      r_s1_a      <= '0;
      r_s1_b      <= '0;
      r_s1_signed <= 1'b0;
      r_s1_op     <= '0;
      r_s1_dest   <= '0;
    end else begin
      if (w_accept) begin
        r_s1_valid  <= 1'b1;
        r_s1_a      <= i_A;
        r_s1_b      <= i_B;
        r_s1_signed <= i_signed;
        r_s1_op     <= i_op;
        r_s1_dest   <= i_dest;
      end else if (w_s2_load) begin
        r_s1_valid  <= 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s2_valid <= 1'b0;
      r_s2_g     <= '0;
      r_s2_dest  <= '0;
      r_s2_we    <= 1'b0;
      r_s2_flags <= '0;
    end else begin
      if (w_s2_load) begin
        r_s2_valid <= 1'b1;
        r_s2_g     <= w_alu_g;
        r_s2_dest  <= r_s1_dest;
        r_s2_we    <= op_writes_reg(r_s1_op);
        r_s2_flags <= w_alu_flags;
      end else if (w_retire) begin
        r_s2_valid <= 1'b0;
      end
    end
  end

  // A retiring error flag takes priority over a same-cycle clear.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_status       <= '0;
      r_sticky_ovf   <= 1'b0;
      r_sticky_undef <= 1'b0;
    end else begin
      if (w_retire) begin
        r_status <= r_s2_flags;
      end
      r_sticky_ovf   <= (r_sticky_ovf && !i_clr_sticky) ||
                        (w_retire && r_s2_flags[FLAG_OVF]);
      r_sticky_undef <= (r_sticky_undef && !i_clr_sticky) ||
                        (w_retire && r_s2_flags[FLAG_UNDEF]);
    end
  end

  assign o_valid        = r_s2_valid;
  assign o_G            = r_s2_g;
  assign o_dest         = r_s2_dest;
  assign o_we           = r_s2_we;
  assign o_flags        = r_s2_flags;
  assign o_status       = r_status;
  assign o_sticky_ovf   = r_sticky_ovf;
  assign o_sticky_undef = r_sticky_undef;
  assign o_busy         = r_s1_valid || r_s2_valid;

endmodule
`default_nettype wire

// File: tb/tb_alu_exec_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_exec_stage
// Description : Scoreboard bench for alu_exec_stage. Directed operations push
//               hand-computed results into a queue; a monitor pops and
//               compares every retiring result.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_exec_stage;
  import alu_exec_stage_pkg::*;

  logic       i_clk;
  logic       i_rst_n;
  logic       i_valid;
  logic       o_ready;
  logic [7:0] i_A;
  logic [7:0] i_B;
  logic       i_signed;
  logic [6:0] i_op;
  logic [2:0] i_dest;
  logic       o_valid;
  logic       i_ready;
  logic [7:0] o_G;
  logic [2:0] o_dest;
  logic       o_we;
  logic [6:0] o_flags;
  logic [6:0] o_status;
  logic       o_sticky_ovf;
  logic       o_sticky_undef;
  logic       i_clr_sticky;
  logic       o_busy;

  typedef struct {
    logic [7:0] g;
    logic [2:0] dest;
    logic       we;
    logic [6:0] flags;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  alu_exec_stage dut (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_valid        (i_valid),
    .o_ready        (o_ready),
    .i_A            (i_A),
    .i_B            (i_B),
    .i_signed       (i_signed),
    .i_op           (i_op),
    .i_dest         (i_dest),
    .o_valid        (o_valid),
    .i_ready        (i_ready),
    .o_G            (o_G),
    .o_dest         (o_dest),
    .o_we           (o_we),
    .o_flags        (o_flags),
    .o_status       (o_status),
    .o_sticky_ovf   (o_sticky_ovf),
    .o_sticky_undef (o_sticky_undef),
    .i_clr_sticky   (i_clr_sticky),
    .o_busy         (o_busy)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every retiring result is compared against the queue head.
  always @(negedge i_clk) begin
    if (i_rst_n && o_valid && i_ready) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got G=%0h dest=%0h, expected no result", o_G, o_dest);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("sb_G",     {24'd0, o_G},     {24'd0, e.g});
        chk("sb_dest",  {29'd0, o_dest},  {29'd0, e.dest});
        chk("sb_we",    {31'd0, o_we},    {31'd0, e.we});
        chk("sb_flags", {25'd0, o_flags}, {25'd0, e.flags});
      end
    end
  end

  // Present an operation until accepted; push its expected result on accept.
  task automatic issue(input logic [6:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic sgn, input logic [2:0] dest,
                       input logic [7:0] eg, input logic ewe, input logic [6:0] ef);
    exp_t e;
    int   n;
    i_valid  = 1'b1;
    i_op     = op;
    i_A      = a;
    i_B      = b;
    i_signed = sgn;
    i_dest   = dest;
    n = 0;
    @(negedge i_clk);
    while (!o_ready && n < 50) begin
      @(negedge i_clk);
      n++;
    end
    if (!o_ready) begin
      checks++;
      errors++;
      $display("FAIL issue_timeout: o_ready stayed 0, expected 1");
    end else begin
      e.g = eg; e.dest = dest; e.we = ewe; e.flags = ef;
      q.push_back(e);
    end
    @(posedge i_clk);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q.size() != 0 || o_busy) && n < 100) begin
      @(negedge i_clk);
      n++;
    end
    chk("drain_queue", q.size(), 0);
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    i_rst_n = 1'b0; i_valid = 1'b0; i_A = '0; i_B = '0; i_signed = 1'b0;
    i_op = '0; i_dest = '0; i_ready = 1'b0; i_clr_sticky = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    chk("rst_valid",  {31'd0, o_valid},        0);
    chk("rst_busy",   {31'd0, o_busy},         0);
    chk("rst_G",      {24'd0, o_G},            0);
    chk("rst_dest",   {29'd0, o_dest},         0);
    chk("rst_we",     {31'd0, o_we},           0);
    chk("rst_flags",  {25'd0, o_flags},        0);
    chk("rst_status", {25'd0, o_status},       0);
    chk("rst_sovf",   {31'd0, o_sticky_ovf},   0);
    chk("rst_sundef", {31'd0, o_sticky_undef}, 0);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    chk("rst_ready", {31'd0, o_ready}, 1);
    @(posedge i_clk);
    #1;

    // ADD F0+20: carry out, unsigned overflow, two-cycle latency
    i_ready = 1'b1;
    issue(MATH_ADD, 8'hF0, 8'h20, 1'b0, 3'd3, 8'h10, 1'b1, 7'h42);
    i_valid = 1'b0;
    @(negedge i_clk);
    chk("lat_cycle1_valid", {31'd0, o_valid}, 0);
    @(negedge i_clk);
    chk("lat_cycle2_valid", {31'd0, o_valid}, 1);
    chk("lat_cycle2_G",     {24'd0, o_G},     32'h10);
    @(negedge i_clk);
    chk("add_sticky_ovf", {31'd0, o_sticky_ovf}, 1);
    drain();

    // Back-to-back ADDs on consecutive cycles
    fork
      begin
        issue(MATH_ADD, 8'd1, 8'd1, 1'b0, 3'd1, 8'd2, 1'b1, 7'h20);
        issue(MATH_ADD, 8'd2, 8'd2, 1'b0, 3'd2, 8'd4, 1'b1, 7'h20);
        issue(MATH_ADD, 8'd3, 8'd3, 1'b0, 3'd3, 8'd6, 1'b1, 7'h20);
        i_valid = 1'b0;
      end
      begin
        int n;
        n = 0;
        @(negedge i_clk);
        while (!o_valid && n < 20) begin
          @(negedge i_clk);
          n++;
        end
        chk("b2b_first_G", {24'd0, o_G}, 2);
        @(negedge i_clk);
        chk("b2b_second_valid", {31'd0, o_valid}, 1);
        chk("b2b_second_G", {24'd0, o_G}, 4);
        @(negedge i_clk);
        chk("b2b_third_valid", {31'd0, o_valid}, 1);
        chk("b2b_third_G", {24'd0, o_G}, 6);
      end
    join
    drain();

    // Backpressure: two ops with i_ready low fill both stages
    i_ready = 1'b0;
    issue(MATH_SUB, 8'd9,  8'd3,  1'b0, 3'd1, 8'd6, 1'b1, 7'h00);
    issue(MATH_AND, 8'h0F, 8'h01, 1'b0, 3'd2, 8'd1, 1'b1, 7'h04);
    i_valid = 1'b0;
    @(negedge i_clk);
    chk("bp_ready",  {31'd0, o_ready}, 0);
    chk("bp_busy",   {31'd0, o_busy},  1);
    chk("bp_valid",  {31'd0, o_valid}, 1);
    chk("bp_G",      {24'd0, o_G},     6);
    chk("bp_dest",   {29'd0, o_dest},  1);
    repeat (3) @(negedge i_clk);
    chk("bp_hold_valid", {31'd0, o_valid}, 1);
    chk("bp_hold_G",     {24'd0, o_G},     6);
    chk("bp_hold_dest",  {29'd0, o_dest},  1);
    chk("bp_hold_flags", {25'd0, o_flags}, 0);
    @(posedge i_clk);
    #1;
    i_ready = 1'b1;
    drain();

    // Divide by zero, sticky clear alone, then clear colliding with a set
    issue(MATH_DIV, 8'd7, 8'd0, 1'b0, 3'd4, 8'hFF, 1'b1, 7'h01);
    i_valid = 1'b0;
    drain();
    chk("div0_sticky_undef", {31'd0, o_sticky_undef}, 1);
    i_clr_sticky = 1'b1;
    @(posedge i_clk);
    #1;
    i_clr_sticky = 1'b0;
    chk("clr_sticky_undef", {31'd0, o_sticky_undef}, 0);
    chk("clr_sticky_ovf",   {31'd0, o_sticky_ovf},   0);
    issue(MATH_DIV, 8'd7, 8'd0, 1'b0, 3'd4, 8'hFF, 1'b1, 7'h01);
    i_valid = 1'b0;
    @(posedge i_clk);
    #1;
    i_clr_sticky = 1'b1;
    @(posedge i_clk);
    #1;
    i_clr_sticky = 1'b0;
    chk("set_wins_sticky_undef", {31'd0, o_sticky_undef}, 1);
    drain();

    // CMP: no register write, equal+zero, status follows retire
    issue(MATH_CMP, 8'd5, 8'd5, 1'b0, 3'd5, 8'h00, 1'b0, 7'h28);
    i_valid = 1'b0;
    @(negedge i_clk);
    chk("cmp_status_before", {25'd0, o_status}, 32'h01);
    drain();
    chk("cmp_status_after", {25'd0, o_status}, 32'h28);

    // Signed overflow, unknown opcode, modulo
    issue(MATH_ADD, 8'h7F, 8'h01, 1'b1, 3'd6, 8'h80, 1'b1, 7'h02);
    issue(7'h7F,    8'd3,  8'd4,  1'b0, 3'd7, 8'h00, 1'b0, 7'h19);
    issue(MATH_MOD, 8'd7,  8'd3,  1'b0, 3'd2, 8'h01, 1'b1, 7'h04);
    i_valid = 1'b0;
    drain();
    chk("sadd_sticky_ovf", {31'd0, o_sticky_ovf}, 1);

    // Reset with both stages full discards everything
    i_ready = 1'b0;
    issue(MATH_ADD, 8'd1, 8'd2, 1'b0, 3'd1, 8'd3, 1'b1, 7'h10);
    issue(MATH_ADD, 8'd3, 8'd4, 1'b0, 3'd2, 8'd7, 1'b1, 7'h10);
    i_valid = 1'b0;
    #2;
    i_rst_n = 1'b0;
    #1;
    chk("midrst_valid",  {31'd0, o_valid},        0);
    chk("midrst_busy",   {31'd0, o_busy},         0);
    chk("midrst_G",      {24'd0, o_G},            0);
    chk("midrst_flags",  {25'd0, o_flags},        0);
    chk("midrst_status", {25'd0, o_status},       0);
    chk("midrst_sovf",   {31'd0, o_sticky_ovf},   0);
    chk("midrst_sundef", {31'd0, o_sticky_undef}, 0);
    q.delete();
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    i_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge i_clk);
      chk("postrst_valid", {31'd0, o_valid}, 0);
    end
    chk("postrst_ready", {31'd0, o_ready}, 1);
    chk("final_queue", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
